// File: rtl/spi_reg_write_master_pkg.sv
// Shared definitions for the SPI register-write master.
//   - Frame geometry: 16-bit write frame {write bit, 7-bit address, 8-bit data},
//     shifted MSB first.
//   - Register map of the attached PWM/output-enable peripheral.
//   - FSM state encoding used by the top level.
//   - build_frame(): assembles a write frame from an address and a data byte.
package spi_reg_write_master_pkg;

    localparam int SPI_FRAME_W   = 16;
    localparam int SPI_WRITE_BIT = 15;
    localparam int SPI_ADDR_W    = 7;
    localparam int SPI_DATA_W    = 8;

    // Peripheral register map
    localparam logic [SPI_ADDR_W-1:0] REG_EN_OUT_7_0  = 7'h00;
    localparam logic [SPI_ADDR_W-1:0] REG_EN_OUT_15_8 = 7'h01;
    localparam logic [SPI_ADDR_W-1:0] REG_EN_PWM_7_0  = 7'h02;
    localparam logic [SPI_ADDR_W-1:0] REG_EN_PWM_15_8 = 7'h03;
    localparam logic [SPI_ADDR_W-1:0] REG_PWM_DUTY    = 7'h04;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_GAP   = 2'd3
    } spi_state_t;

    // The address is forwarded unchecked; only the write bit is forced.
    function automatic logic [SPI_FRAME_W-1:0] build_frame(
        input logic [SPI_ADDR_W-1:0] addr,
        input logic [SPI_DATA_W-1:0] data
    );
        logic [SPI_FRAME_W-1:0] f;
        f = {1'b0, addr, data};
        f[SPI_WRITE_BIT] = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/spi_reg_write_master_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   req[1:0] : request vector (bit 0 = A, bit 1 = B)
//   advance  : a grant was taken this cycle; update the pointer
//   grant    : one-hot grant, combinational
//   last_reg : pointer flop, requester served last (0 = A, 1 = B)
// The pointer resets to "B served last" so that A wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       last_reg
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_reg ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg <= 1'b1;
        end else if (advance) begin
            last_reg <= grant[1];
        end
    end

endmodule

// File: rtl/spi_reg_write_master.sv
// spi_reg_write_master: arbitrates between two write requesters and sends
// each accepted request as one 16-bit SPI write frame (mode 0, MSB first).
//   clk, rst                         : system clock, async active-high reset
//   a_valid/a_addr/a_data/a_ready    : requester A handshake
//   b_valid/b_addr/b_data/b_ready    : requester B handshake
//   spi_ncs, spi_sclk, spi_copi      : 3-wire SPI link to the peripheral
//   busy                             : a frame is in progress (SHIFT/HOLD/GAP)
//   frame_done                       : one-cycle pulse as nCS deasserts
//   frame_src                        : requester of the current/last frame
// Every SPI output is decoded from async-reset state, so a reset aborts a
// frame in the same cycle: nCS rises with SCLK low, and the peripheral never
// sees a 16-bit frame complete.
module spi_reg_write_master
    import spi_reg_write_master_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [SPI_ADDR_W-1:0] a_addr,
    input  logic [SPI_DATA_W-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [SPI_ADDR_W-1:0] b_addr,
    input  logic [SPI_DATA_W-1:0] b_data,
    output logic                  b_ready,
    output logic                  spi_ncs,
    output logic                  spi_sclk,
    output logic                  spi_copi,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_src
);

    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [4:0]    BITS_TERM = 5'(SPI_FRAME_W);

    spi_state_t             state_reg,   state_next;
    logic [CW-1:0]          cnt_reg,     cnt_next;
    logic                   phase_reg,   phase_next;   // 0 = SCLK low half, 1 = high half
    logic [4:0]             bit_cnt_reg, bit_cnt_next;
    logic [SPI_FRAME_W-1:0] shift_reg,   shift_next;
    logic                   served_reg,  served_next;  // at least one frame accepted since reset

    logic [1:0] grant;
    logic       last_ptr;
    logic       accept;
    logic [4:0] bit_inc;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      ({b_valid, a_valid}),
        .advance  (accept),
        .grant    (grant),
        .last_reg (last_ptr)
    );

    // The arbiter pointer already records who was accepted last; it only
    // differs from the required frame_src before the first acceptance, where
    // the pointer says B but frame_src must read A.
    assign frame_src = served_reg & last_ptr;

    assign bit_inc = bit_cnt_reg + 5'd1;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        phase_next   = phase_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        served_next  = served_reg;
        accept       = 1'b0;
        a_ready      = 1'b0;
        b_ready      = 1'b0;
        spi_ncs      = 1'b1;
        spi_sclk     = 1'b0;
        spi_copi     = 1'b0;
        busy         = 1'b0;
        frame_done   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Gated by rst so ready reads low while reset is held.
                a_ready = grant[0] & ~rst;
                b_ready = grant[1] & ~rst;
                accept  = a_ready | b_ready;
                if (accept) begin
                    shift_next   = grant[1] ? build_frame(b_addr, b_data)
                                            : build_frame(a_addr, a_data);
                    served_next  = 1'b1;
                    cnt_next     = '0;
                    phase_next   = 1'b0;
                    bit_cnt_next = '0;
                    state_next   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                busy     = 1'b1;
                spi_ncs  = 1'b0;
                spi_sclk = phase_reg;
                spi_copi = shift_reg[SPI_FRAME_W-1];
                if (cnt_reg == DIV_LAST) begin
                    cnt_next = '0;
                    if (!phase_reg) begin
                        phase_next = 1'b1;
                    end else begin
                        // Data advances only as SCLK falls, so COPI is stable
                        // across the mid-bit rising edge.
                        phase_next   = 1'b0;
                        shift_next   = {shift_reg[SPI_FRAME_W-2:0], 1'b0};
                        bit_cnt_next = bit_inc;
                        if (bit_inc == BITS_TERM) begin
                            state_next = ST_HOLD;
                        end
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_HOLD: begin
                busy    = 1'b1;
                spi_ncs = 1'b0;
                if (cnt_reg == DIV_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_GAP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_GAP: begin
                busy       = 1'b1;
                frame_done = (cnt_reg == '0);
                if (cnt_reg == GAP_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            phase_reg   <= 1'b0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            served_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            phase_reg   <= phase_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            served_reg  <= served_next;
        end
    end

endmodule
